// File: rtl/serial_comp_ctrl.sv
// ---------------------------------------------------------------------------
// serial_comp_ctrl
//   Sequential magnitude comparator for two WIDTH-bit unsigned operands. A
//   single 2-bit comparator slice is stepped over the operands, MSB pair
//   first, under a start/busy/done handshake.
//
//   Optional build macro: SERIAL_COMP_EARLY_EXIT_EN
//     defined   : COMPARE exits on the first unequal slice.
//     undefined : every slice is always evaluated (constant latency NSLICE);
//                 the first unequal slice is held in a sticky flag.
//
//   Ports
//     clk     in   system clock, rising edge
//     rst     in   asynchronous active-high reset
//     start   in   request, sampled only in IDLE
//     a, b    in   WIDTH-bit operands, captured on accepted start
//     busy    out  high from accepted start through the done cycle
//     done    out  one-cycle pulse when the result is valid
//     a_eq_b  out  registered result A == B
//     a_gt_b  out  registered result A >  B
//     a_lt_b  out  registered result A <  B
// ---------------------------------------------------------------------------
module serial_comp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    localparam int unsigned NSLICE = WIDTH / 2;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_eq, w_eq_nxt;
    logic               r_gt, w_gt_nxt;
    logic               r_lt, w_lt_nxt;

    logic [1:0]         w_sa;
    logic [1:0]         w_sb;
    logic               w_slice_gt;
    logic               w_slice_lt;
    logic               w_slice_eq;
    logic               w_last;

`ifndef SERIAL_COMP_EARLY_EXIT_EN
    logic               r_dec, w_dec_nxt;
    logic               r_sgt, w_sgt_nxt;
    logic               r_slt, w_slt_nxt;
    logic               w_dec;
    logic               w_fgt;
    logic               w_flt;
`endif

    // 2-bit slice compare on the top pair of each shift register
    assign w_sa       = r_a[WIDTH-1 -: 2];
    assign w_sb       = r_b[WIDTH-1 -: 2];
    assign w_slice_gt = (w_sa[1] & ~w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & w_sa[0] & ~w_sb[0]);
    assign w_slice_lt = (~w_sa[1] & w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & ~w_sa[0] & w_sb[0]);
    assign w_slice_eq = ~(w_slice_gt | w_slice_lt);
    assign w_last     = (r_cnt == '0);

`ifndef SERIAL_COMP_EARLY_EXIT_EN
    // First unequal slice wins; later slices cannot override it
    assign w_dec = r_dec | ~w_slice_eq;
    assign w_fgt = r_dec ? r_sgt : w_slice_gt;
    assign w_flt = r_dec ? r_slt : w_slice_lt;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            r_dec   <= 1'b0;
            r_sgt   <= 1'b0;
            r_slt   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_eq    <= w_eq_nxt;
            r_gt    <= w_gt_nxt;
            r_lt    <= w_lt_nxt;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
            r_dec   <= w_dec_nxt;
            r_sgt   <= w_sgt_nxt;
            r_slt   <= w_slt_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_eq_nxt    = r_eq;
        w_gt_nxt    = r_gt;
        w_lt_nxt    = r_lt;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
        w_dec_nxt   = r_dec;
        w_sgt_nxt   = r_sgt;
        w_slt_nxt   = r_slt;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COMPARE;
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_cnt_nxt   = CNT_W'(NSLICE - 1);
                    w_busy_nxt  = 1'b1;
                    w_eq_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
`ifndef SERIAL_COMP_EARLY_EXIT_EN
                    w_dec_nxt   = 1'b0;
                    w_sgt_nxt   = 1'b0;
                    w_slt_nxt   = 1'b0;
`endif
                end
            end

            S_COMPARE: begin
                w_busy_nxt = 1'b1;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                if (!w_slice_eq) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_eq_nxt    = 1'b0;
                    w_gt_nxt    = w_slice_gt;
                    w_lt_nxt    = w_slice_lt;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_eq_nxt    = 1'b1;
                    w_gt_nxt    = 1'b0;
                    w_lt_nxt    = 1'b0;
                end else begin
                    w_a_nxt   = r_a << 2;
                    w_b_nxt   = r_b << 2;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
`else
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_eq_nxt    = ~w_dec;
                    w_gt_nxt    = w_fgt;
                    w_lt_nxt    = w_flt;
                end else begin
                    w_a_nxt   = r_a << 2;
                    w_b_nxt   = r_b << 2;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_dec_nxt = w_dec;
                    w_sgt_nxt = w_fgt;
                    w_slt_nxt = w_flt;
                end
`endif
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign a_eq_b = r_eq;
    assign a_gt_b = r_gt;
    assign a_lt_b = r_lt;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed, table-driven bench for serial_comp_ctrl (WIDTH = 8).
module tb_serial_comp_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       a_eq_b;
    logic       a_gt_b;
    logic       a_lt_b;

    int n_checks = 0;
    int n_errors = 0;

    serial_comp_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_eq_b (a_eq_b),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       eq;
        logic       gt;
        logic       lt;
        int         lat_en;   // latency with early exit
        int         lat_dis;  // latency without early exit
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pick_lat(input int l_en, input int l_dis);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        return l_en;
`else
        return l_dis;
`endif
    endfunction

    // Called at a negedge; leaves the bench at a negedge one cycle after done.
    task automatic run_vec(input string nm, input logic [7:0] va, input logic [7:0] vb,
                           input logic e_eq, input logic e_gt, input logic e_lt,
                           input int e_lat);
        int  n;
        int  nbusy;
        bit  seen;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk);
        start = 1'b0;
        a     = ~va;                    // operand change after capture must not matter
        b     = ~vb;
        check({nm, " busy_after_start"}, int'(busy), 1);
        check({nm, " cleared"}, int'({a_eq_b, a_gt_b, a_lt_b}), 0);
        n     = 0;
        nbusy = 1;
        seen  = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        check({nm, " done_seen"}, int'(seen), 1);
        check({nm, " latency"}, n, e_lat);
        check({nm, " busy_cycles"}, nbusy, e_lat + 1);
        check({nm, " result"}, int'({a_eq_b, a_gt_b, a_lt_b}), int'({e_eq, e_gt, e_lt}));
        @(negedge clk);
        check({nm, " idle_busy_done"}, int'({busy, done}), 0);
        check({nm, " result_hold"}, int'({a_eq_b, a_gt_b, a_lt_b}), int'({e_eq, e_gt, e_lt}));
    endtask

    initial begin
        int n;
        bit seen;

        vecs[0]  = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 4, 4};
        vecs[1]  = '{8'hC0, 8'h40, 1'b0, 1'b1, 1'b0, 1, 4};
        vecs[2]  = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4, 4};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4, 4};
        vecs[4]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1, 4};
        vecs[5]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1, 4};
        vecs[6]  = '{8'h34, 8'h38, 1'b0, 1'b0, 1'b1, 3, 4};
        vecs[7]  = '{8'h81, 8'h7F, 1'b0, 1'b1, 1'b0, 1, 4};
        vecs[8]  = '{8'h5A, 8'h59, 1'b0, 1'b1, 1'b0, 4, 4};
        vecs[9]  = '{8'h40, 8'h3F, 1'b0, 1'b1, 1'b0, 1, 4};
        vecs[10] = '{8'h2D, 8'h2E, 1'b0, 1'b0, 1'b1, 4, 4};
        vecs[11] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 4, 4};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_outputs", int'({busy, done, a_eq_b, a_gt_b, a_lt_b}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", int'({busy, done, a_eq_b, a_gt_b, a_lt_b}), 0);
        end

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                    vecs[i].eq, vecs[i].gt, vecs[i].lt,
                    pick_lat(vecs[i].lat_en, vecs[i].lat_dis));
        end

        // start and operand change during COMPARE are ignored
        a     = 8'h12;
        b     = 8'h13;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check("busy_start done_seen", int'(seen), 1);
        check("busy_start result", int'({a_eq_b, a_gt_b, a_lt_b}), 3'b001);
        @(negedge clk);
        // Fresh start clears results before new compare
        run_vec("after_ignored", 8'hC0, 8'h40, 1'b0, 1'b1, 1'b0, pick_lat(1, 4));

        // Async reset mid-COMPARE
        a     = 8'hA5;
        b     = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({busy, done, a_eq_b, a_gt_b, a_lt_b}), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("async_reset_no_done", int'(seen), 0);
        rst = 1'b0;
        @(negedge clk);
        run_vec("after_reset", 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
